// File: rtl/stream_gen.sv
// AXI-Stream test-pattern source under ap_ctrl_hs control: byte/word ramp, constant, optional LFSR.
// Define STREAM_GEN_LFSR_EN to build the mode-3 LFSR; otherwise mode 3 is a byte ramp.
module stream_gen #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  input  logic [31:0]      size,
  input  logic [15:0]      burst_beats,
  input  logic [1:0]       mode,
  input  logic [31:0]      seed,
  output logic             ap_ready,
  output logic             ap_done,
  output logic             ap_idle,
  output logic [WIDTH-1:0] tdata,
  output logic             tvalid,
  output logic             tlast,
  input  logic             tready
);

  localparam int unsigned LANES = WIDTH / 32;
  localparam int unsigned BYTES = WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [31:0]      size_q, size_d, seed_q, seed_d, beat_q, beat_d;
  logic [15:0]      burst_q, burst_d, frame_q, frame_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic             ap_ready_q, ap_ready_d, ap_done_q, ap_done_d, ap_idle_q, ap_idle_d;
  logic             accept, final_beat;

`ifdef STREAM_GEN_LFSR_EN
  localparam logic [31:0] LfsrPoly = 32'h8020_0003;
  logic [31:0] lfsr_q, lfsr_d;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LfsrPoly) : (s >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] lfsr_lanes(input logic [31:0] s);
    logic [WIDTH-1:0] d;
    for (int k = 0; k < LANES; k++) d[32*k +: 32] = s ^ 32'(k);
    return d;
  endfunction
`endif

  function automatic logic [WIDTH-1:0] pattern(input logic [1:0]  m,
                                               input logic [31:0] s,
                                               input logic [31:0] b);
    logic [WIDTH-1:0] d;
    logic [7:0]       byte_base;
    logic [31:0]      word_base;
    d         = '0;
    byte_base = s[7:0] + 8'(b * BYTES);
    word_base = s + 32'(b * LANES);
    case (m)
      2'd1:    for (int k = 0; k < LANES; k++) d[32*k +: 32] = word_base + 32'(k);
      2'd2:    for (int k = 0; k < LANES; k++) d[32*k +: 32] = s;
      default: for (int j = 0; j < BYTES; j++) d[8*j +: 8] = byte_base + 8'(j);
    endcase
    return d;
  endfunction

  // Frame position is tracked separately from the beat index so no modulo is needed.
  function automatic logic is_last(input logic [15:0] frame, input logic [15:0] burst,
                                   input logic [31:0] b, input logic [31:0] sz);
    return ((burst != 16'd0) && (frame == burst - 16'd1)) || (b == sz - 32'd1);
  endfunction

  assign accept     = tvalid_q & tready;
  assign final_beat = (beat_q == size_q - 32'd1);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= StIdle;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ap_start) state_d = (size == 32'd0) ? StDone : StRun;
      StRun:   if (accept && final_beat) state_d = StDone;
      StDone:  if (ap_done_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output registers are loaded with the next beat's values so everything leaves a flop.
  always_comb begin
    size_d     = size_q;
    burst_d    = burst_q;
    mode_d     = mode_q;
    seed_d     = seed_q;
    beat_d     = beat_q;
    frame_d    = frame_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    ap_ready_d = 1'b0;
    ap_done_d  = 1'b0;
    ap_idle_d  = (state_d == StIdle);
`ifdef STREAM_GEN_LFSR_EN
    lfsr_d     = lfsr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          size_d     = size;
          burst_d    = burst_beats;
          mode_d     = mode;
          seed_d     = seed;
          beat_d     = '0;
          frame_d    = '0;
          ap_ready_d = 1'b1;
`ifdef STREAM_GEN_LFSR_EN
          lfsr_d     = (seed == 32'd0) ? 32'd1 : seed;
`endif
          if (size != 32'd0) begin
            tvalid_d = 1'b1;
            tdata_d  = pattern(mode, seed, 32'd0);
            tlast_d  = is_last(16'd0, burst_beats, 32'd0, size);
`ifdef STREAM_GEN_LFSR_EN
            if (mode == 2'd3) tdata_d = lfsr_lanes(lfsr_d);
`endif
          end
        end
      end
      StRun: begin
        if (accept) begin
          if (final_beat) begin
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            ap_done_d = 1'b1;
          end else begin
            beat_d  = beat_q + 32'd1;
            frame_d = ((burst_q != 16'd0) && (frame_q == burst_q - 16'd1)) ? 16'd0
                                                                            : frame_q + 16'd1;
            tdata_d = pattern(mode_q, seed_q, beat_d);
            tlast_d = is_last(frame_d, burst_q, beat_d, size_q);
`ifdef STREAM_GEN_LFSR_EN
            lfsr_d  = lfsr_step(lfsr_q);
            if (mode_q == 2'd3) tdata_d = lfsr_lanes(lfsr_d);
`endif
          end
        end
      end
      // A zero-size command enters DONE without a pulse pending, so it raises one here.
      StDone:  ap_done_d = ~ap_done_q;
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      size_q     <= '0;
      burst_q    <= '0;
      mode_q     <= '0;
      seed_q     <= '0;
      beat_q     <= '0;
      frame_q    <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      ap_ready_q <= 1'b0;
      ap_done_q  <= 1'b0;
      ap_idle_q  <= 1'b1;
`ifdef STREAM_GEN_LFSR_EN
      lfsr_q     <= 32'd1;
`endif
    end else begin
      size_q     <= size_d;
      burst_q    <= burst_d;
      mode_q     <= mode_d;
      seed_q     <= seed_d;
      beat_q     <= beat_d;
      frame_q    <= frame_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      ap_ready_q <= ap_ready_d;
      ap_done_q  <= ap_done_d;
      ap_idle_q  <= ap_idle_d;
`ifdef STREAM_GEN_LFSR_EN
      lfsr_q     <= lfsr_d;
`endif
    end
  end

  assign tdata    = tdata_q;
  assign tvalid   = tvalid_q;
  assign tlast    = tlast_q;
  assign ap_ready = ap_ready_q;
  assign ap_done  = ap_done_q;
  assign ap_idle  = ap_idle_q;

endmodule

// File: tb/tb_stream_gen.sv
// Bench for stream_gen: 32- and 128-bit instances in lockstep, table rows plus random commands
// checked against a queue-based pattern model; follows STREAM_GEN_LFSR_EN for mode 3.
module tb_stream_gen;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic         ap_start = 1'b0;
  logic         tready = 1'b0;
  logic [31:0]  size = '0;
  logic [31:0]  seed = '0;
  logic [15:0]  burst_beats = '0;
  logic [1:0]   mode = '0;

  logic         r32, d32, i32, v32, l32;
  logic         r128, d128, i128, v128, l128;
  logic [31:0]  td32;
  logic [127:0] td128;

  stream_gen #(.WIDTH(32)) u_dut32 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .size(size),
    .burst_beats(burst_beats), .mode(mode), .seed(seed), .ap_ready(r32), .ap_done(d32),
    .ap_idle(i32), .tdata(td32), .tvalid(v32), .tlast(l32), .tready(tready)
  );

  stream_gen #(.WIDTH(128)) u_dut128 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .size(size),
    .burst_beats(burst_beats), .mode(mode), .seed(seed), .ap_ready(r128), .ap_done(d128),
    .ap_idle(i128), .tdata(td128), .tvalid(v128), .tlast(l128), .tready(tready)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [31:0]  d32;
    logic [127:0] d128;
    logic         last;
  } beat_t;

  typedef struct {
    logic [31:0]  size;
    logic [15:0]  burst;
    logic [1:0]   mode;
    logic [31:0]  seed;
    bit           rnd;
    logic [31:0]  first32;
    logic [127:0] first128;
    int           tlasts;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[8];
  int    n_vec = 0;
  int    n_bad = 0;
  int    done_in = 0;
  bit    busy = 1'b0;
  bit    ready_due = 1'b0;
  int    tl_cnt = 0;
  int    hs_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [127:0] model_data(input int w, input logic [1:0] md,
                                              input logic [31:0] sd, input int b,
                                              input logic [31:0] lf);
    logic [127:0] r;
    int nbytes;
    int lanes;
    int m;
    r      = '0;
    nbytes = w / 8;
    lanes  = w / 32;
    m      = int'(md);
`ifndef STREAM_GEN_LFSR_EN
    if (m == 3) m = 0;
`endif
    case (m)
      0:       for (int j = 0; j < nbytes; j++) r[8*j +: 8] = 8'(int'(sd[7:0]) + b * nbytes + j);
      1:       for (int k = 0; k < lanes; k++) r[32*k +: 32] = sd + 32'(b * lanes + k);
      2:       for (int k = 0; k < lanes; k++) r[32*k +: 32] = sd;
      default: for (int k = 0; k < lanes; k++) r[32*k +: 32] = lf ^ 32'(k);
    endcase
    return r;
  endfunction

  task automatic build_queue(input int sz, input int bb, input logic [1:0] md,
                             input logic [31:0] sd);
    beat_t        e;
    logic [127:0] t;
    logic [31:0]  lf;
    lf = (sd == 32'd0) ? 32'd1 : sd;
    exp_q.delete();
    for (int b = 0; b < sz; b++) begin
      t      = model_data(32, md, sd, b, lf);
      e.d32  = t[31:0];
      e.d128 = model_data(128, md, sd, b, lf);
      e.last = ((bb != 0) && ((b + 1) % bb == 0)) || (b == sz - 1);
      exp_q.push_back(e);
      lf = lfsr_next(lf);
    end
  endtask

  // Called once per cycle at the falling edge, after tready for the coming edge is set.
  task automatic monitor();
    bit exp_done;
    bit exp_valid;
    exp_done = (done_in == 1);
    if (done_in > 0) done_in--;
    exp_valid = (exp_q.size() != 0);
    chk("tvalid32", v32, exp_valid);
    chk("tvalid128", v128, exp_valid);
    chk("ap_ready32", r32, ready_due);
    chk("ap_ready128", r128, ready_due);
    ready_due = 1'b0;
    chk("ap_done32", d32, exp_done);
    chk("ap_done128", d128, exp_done);
    chk("ap_idle32", i32, !busy);
    chk("ap_idle128", i128, !busy);
    if (exp_done) busy = 1'b0;
    if (exp_valid && v32) begin
      chk("tdata32", td32, exp_q[0].d32);
      chk("tlast32", l32, exp_q[0].last);
      chk("tdata128", td128, exp_q[0].d128);
      chk("tlast128", l128, exp_q[0].last);
      if (tready) begin
        if (exp_q[0].last) tl_cnt++;
        hs_cnt++;
        if (exp_q.size() == 1) done_in = 1;
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tvalid"}, {v32, v128}, 2'b00);
    chk({tag, "_tlast"}, {l32, l128}, 2'b00);
    chk({tag, "_tdata32"}, td32, 32'd0);
    chk({tag, "_tdata128"}, td128, 128'd0);
    chk({tag, "_ready_done"}, {r32, r128, d32, d128}, 4'b0000);
    chk({tag, "_idle"}, {i32, i128}, 2'b11);
  endtask

  task automatic run_cmd(input vec_t v, input bit chk_tab);
    int n;
    build_queue(int'(v.size), int'(v.burst), v.mode, v.seed);
    tl_cnt    = 0;
    hs_cnt    = 0;
    busy      = 1'b1;
    ready_due = 1'b1;
    if (v.size == 32'd0) done_in = 2;
    size        = v.size;
    burst_beats = v.burst;
    mode        = v.mode;
    seed        = v.seed;
    ap_start    = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    if (chk_tab && v.size != 32'd0) begin
      chk("first_beat32", td32, v.first32);
      chk("first_beat128", td128, v.first128);
    end
    n = 0;
    while (busy && n < 300) begin
      tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      monitor();
      @(negedge ap_clk);
      n++;
    end
    chk("cmd_timeout", busy, 1'b0);
    if (busy) begin
      exp_q.delete();
      busy    = 1'b0;
      done_in = 0;
    end
    monitor();
    chk("handshakes", hs_cnt, v.size);
    if (chk_tab) chk("tlast_count", tl_cnt, v.tlasts);
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{32'd4, 16'd0, 2'd0, 32'h80, 1'b0, 32'h8382_8180,
                128'h8F8E8D8C_8B8A8988_87868584_83828180, 1};
    vecs[1] = '{32'd2, 16'd0, 2'd1, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFE,
                128'h00000001_00000000_FFFFFFFF_FFFFFFFE, 1};
    vecs[2] = '{32'd10, 16'd4, 2'd2, 32'hA5A5_1234, 1'b1, 32'hA5A5_1234,
                128'hA5A51234_A5A51234_A5A51234_A5A51234, 3};
    vecs[3] = '{32'd0, 16'd3, 2'd0, 32'h55, 1'b0, 32'd0, 128'd0, 0};
    vecs[4] = '{32'd1, 16'd5, 2'd0, 32'h0, 1'b0, 32'h0302_0100,
                128'h0F0E0D0C_0B0A0908_07060504_03020100, 1};
    vecs[5] = '{32'd6, 16'd1, 2'd1, 32'h10, 1'b1, 32'h10,
                128'h00000013_00000012_00000011_00000010, 6};
`ifdef STREAM_GEN_LFSR_EN
    vecs[6] = '{32'd3, 16'd2, 2'd3, 32'h1, 1'b1, 32'h1,
                128'h00000002_00000003_00000000_00000001, 2};
    vecs[7] = '{32'd3, 16'd2, 2'd3, 32'h0, 1'b1, 32'h1,
                128'h00000002_00000003_00000000_00000001, 2};
`else
    vecs[6] = '{32'd3, 16'd2, 2'd3, 32'h1, 1'b1, 32'h0403_0201,
                128'h100F0E0D_0C0B0A09_08070605_04030201, 2};
    vecs[7] = '{32'd3, 16'd2, 2'd3, 32'h0, 1'b1, 32'h0302_0100,
                128'h0F0E0D0C_0B0A0908_07060504_03020100, 2};
`endif

    repeat (2) @(negedge ap_clk);
    chk_reset_outputs("reset");
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    monitor();
    @(negedge ap_clk);

    for (int i = 0; i < 8; i++) run_cmd(vecs[i], 1'b1);

    for (int i = 0; i < 14; i++) begin
      rv.size     = 32'($urandom_range(0, 24));
      rv.burst    = 16'($urandom_range(0, 6));
      rv.mode     = 2'($urandom_range(0, 3));
      rv.seed     = $urandom;
      rv.rnd      = 1'($urandom_range(0, 1));
      rv.first32  = '0;
      rv.first128 = '0;
      rv.tlasts   = 0;
      run_cmd(rv, 1'b0);
    end

    // Reset mid-command: three beats taken, then the stream is dropped.
    build_queue(8, 0, 2'd0, 32'h20);
    tl_cnt      = 0;
    hs_cnt      = 0;
    busy        = 1'b1;
    ready_due   = 1'b1;
    size        = 32'd8;
    burst_beats = 16'd0;
    mode        = 2'd0;
    seed        = 32'h20;
    ap_start    = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    tready   = 1'b1;
    repeat (3) begin
      monitor();
      @(negedge ap_clk);
    end
    chk("pre_reset_handshakes", hs_cnt, 3);
    ap_rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    exp_q.delete();
    busy      = 1'b0;
    done_in   = 0;
    ready_due = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (4) begin
      monitor();
      @(negedge ap_clk);
    end
    run_cmd(vecs[0], 1'b1);
    run_cmd(vecs[2], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
